// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus between the program loader and instr_encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
) ();
    logic              req_valid_i;
    logic              req_ready_o;
    logic [3:0]        req_kind_i;
    logic [4:0]        req_rs_i;
    logic [4:0]        req_rt_i;
    logic [4:0]        req_rd_i;
    logic [4:0]        req_shamt_i;
    logic [31:0]       req_imm_i;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;

    modport master (
        output req_valid_i, req_kind_i, req_rs_i, req_rt_i, req_rd_i, req_shamt_i, req_imm_i,
        input  req_ready_o, mem_we_o, mem_addr_o, mem_data_o
    );

    modport slave (
        input  req_valid_i, req_kind_i, req_rs_i, req_rt_i, req_rd_i, req_shamt_i, req_imm_i,
        output req_ready_o, mem_we_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs field-level requests into 32-bit MIPS words and writes them sequentially
// into instruction memory; LI expands to LUI+ORI over two cycles.
module instr_encoder #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            restart_i,
    instr_encoder_if.slave  bus,
    output logic            err_o,
    output logic            full_o,
    output logic [ADDR_W:0] count_o
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_EMIT2, S_FULL} state_e;

    typedef enum logic [3:0] {
        K_ADD  = 4'd0,  K_SUB  = 4'd1,  K_AND  = 4'd2,  K_OR   = 4'd3,
        K_SLT  = 4'd4,  K_SLL  = 4'd5,  K_SRLV = 4'd6,  K_ADDI = 4'd7,
        K_SLTI = 4'd8,  K_BEQ  = 4'd9,  K_BNE  = 4'd10, K_LUI  = 4'd11,
        K_ORI  = 4'd12, K_LI   = 4'd13
    } kind_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       ori_q, ori_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              full_q, full_d;

    logic              ready;
    logic              accept;
    logic              legal;
    logic              last_slot;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       imm_field;

    function automatic logic [31:0] encode_word(
        input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [4:0] shamt, input logic [15:0] imm
    );
        logic [31:0] w;
        w = '0;
        case (kind)
            K_ADD:        w = {6'd0, rs, rt, rd, 5'd0, 6'd32};
            K_SUB:        w = {6'd0, rs, rt, rd, 5'd0, 6'd34};
            K_AND:        w = {6'd0, rs, rt, rd, 5'd0, 6'd36};
            K_OR:         w = {6'd0, rs, rt, rd, 5'd0, 6'd37};
            K_SLT:        w = {6'd0, rs, rt, rd, 5'd0, 6'd42};
            K_SLL:        w = {6'd0, rs, rt, rd, shamt, 6'd0};
            K_SRLV:       w = {6'd0, rs, rt, rd, 5'd0, 6'd6};
            K_ADDI:       w = {6'd8, rs, rt, imm};
            K_SLTI:       w = {6'd10, rs, rt, imm};
            K_BEQ:        w = {6'd4, rs, rt, imm};
            K_BNE:        w = {6'd5, rs, rt, imm};
            K_LUI, K_LI:  w = {6'd15, 5'd0, rt, imm};
            K_ORI:        w = {6'd13, rs, rt, imm};
            default:      w = '0;
        endcase
        return w;
    endfunction

    assign ready           = (state_q == S_IDLE) & ~full_q & ~restart_i;
    assign bus.req_ready_o = ready;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_data_o  = data_q;
    assign err_o           = err_q;
    assign full_o          = full_q;
    assign count_o         = count_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        data_d    = data_q;
        ori_d     = ori_q;
        full_d    = full_q;
        we_d      = 1'b0;
        err_d     = 1'b0;
        accept    = bus.req_valid_i & ready;
        legal     = (bus.req_kind_i <= K_LI);
        wr_addr   = BASE + count_q[ADDR_W-1:0];
        last_slot = (wr_addr == '1);
        imm_field = (bus.req_kind_i == K_LI) ? bus.req_imm_i[31:16] : bus.req_imm_i[15:0];

        if (restart_i) begin
            state_d = S_IDLE;
            count_d = '0;
            addr_d  = BASE;
            full_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        // An LI needs two slots; with only one left it is rejected whole.
                        if (!legal || (bus.req_kind_i == K_LI && last_slot)) begin
                            err_d = 1'b1;
                        end else begin
                            we_d    = 1'b1;
                            addr_d  = wr_addr;
                            count_d = count_q + 1'b1;
                            data_d  = encode_word(bus.req_kind_i, bus.req_rs_i, bus.req_rt_i,
                                                  bus.req_rd_i, bus.req_shamt_i, imm_field);
                            ori_d   = {6'd13, bus.req_rt_i, bus.req_rt_i, bus.req_imm_i[15:0]};
                            if (last_slot) begin
                                state_d = S_FULL;
                                full_d  = 1'b1;
                            end else if (bus.req_kind_i == K_LI) begin
                                state_d = S_EMIT2;
                            end
                        end
                    end
                end
                S_EMIT2: begin
                    we_d    = 1'b1;
                    addr_d  = wr_addr;
                    data_d  = ori_q;
                    count_d = count_q + 1'b1;
                    if (last_slot) begin
                        state_d = S_FULL;
                        full_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FULL:  state_d = S_FULL;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
            addr_q  <= BASE;
            data_q  <= '0;
            ori_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ori_q   <= ori_d;
            we_q    <= we_d;
            err_q   <= err_d;
            full_q  <= full_d;
        end
    end
endmodule
